// File: rtl/spi_omega_master.sv
// SPI mode-0 master that shifts one DATA_W-bit tuning word per frame, MSB first,
// to the omega receiver. Every output comes straight from a flop.
module spi_omega_master #(
  parameter int unsigned DATA_W   = 40,
  parameter int unsigned HALF_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              sck,
  output logic              mosi,
  output logic              ssel,
  output logic              busy,
  output logic              done
);

  localparam int unsigned HW = $clog2(HALF_DIV + 1);
  localparam int unsigned BW = $clog2(DATA_W + 1);

  localparam logic [HW-1:0] HalfLast = HW'(HALF_DIV - 1);
  localparam logic [BW-1:0] BitLast  = BW'(DATA_W - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLow   = 3'd1;
  localparam logic [2:0] StHigh  = 3'd2;
  localparam logic [2:0] StTrail = 3'd3;
  localparam logic [2:0] StGap   = 3'd4;

  if (HALF_DIV < 1) begin : gen_bad_div
    $error("HALF_DIV must be at least 1");
  end
  if (DATA_W < 2) begin : gen_bad_width
    $error("DATA_W must be at least 2");
  end

  logic [2:0]        state_q, state_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              ssel_q, ssel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              half_end;

  assign half_end = (hcnt_q == HalfLast);

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ssel_d  = ssel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          shreg_d = data_in;
          mosi_d  = data_in[DATA_W-1];
          ssel_d  = 1'b0;
          sck_d   = 1'b0;
          busy_d  = 1'b1;
          hcnt_d  = '0;
          bcnt_d  = '0;
          state_d = StLow;
        end
      end

      StLow: begin
        if (half_end) begin
          hcnt_d  = '0;
          sck_d   = 1'b1;
          state_d = StHigh;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      StHigh: begin
        if (half_end) begin
          hcnt_d = '0;
          sck_d  = 1'b0;
          // Next bit lands on mosi in the same cycle sck falls.
          if (bcnt_q == BitLast) begin
            mosi_d  = 1'b0;
            state_d = StTrail;
          end else begin
            bcnt_d  = bcnt_q + 1'b1;
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            mosi_d  = shreg_q[DATA_W-2];
            state_d = StLow;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      StTrail: begin
        if (half_end) begin
          hcnt_d  = '0;
          ssel_d  = 1'b1;
          state_d = StGap;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      StGap: begin
        if (half_end) begin
          hcnt_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      default: begin
        hcnt_d  = '0;
        bcnt_d  = '0;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
        ssel_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ssel_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ssel_q  <= ssel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sck  = sck_q;
  assign mosi = mosi_q;
  assign ssel = ssel_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
